// File: rtl/interrupt_controller.sv
// Seven-source edge-triggered interrupt controller with pending/mask registers on the I/O bus.
// Optional feature macro INTC_MASK_REG_EN: when undefined the mask is fixed at 8'hFF.
module interrupt_controller #(
    parameter logic [15:0] BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  irq,
    input  logic        iret,
    input  logic        enable_wishbone,
    input  logic        wr,
    input  logic [15:0] dir,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic [2:0]  interrupciones,
    output logic        in_service
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        SERVICE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      nextState_s;
    logic [6:0]  pending_r;
    logic [6:0]  irqPrev_r;
    logic [6:0]  rise_s;
    logic [6:0]  eligible_s;
    logic [6:0]  w1c_s;
    logic [6:0]  dispatchClr_s;
    logic [7:0]  mask_s;
    logic [2:0]  dispIdx_s;
    logic        dispatch_s;
    logic        busWrite_s;
    logic        busRead_s;
    logic        unusedDinMsb_s;

    function automatic logic [2:0] lowestSet(input logic [6:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign busWrite_s     = enable_wishbone & wr;
    assign busRead_s      = enable_wishbone & ~wr;
    assign rise_s         = irq & ~irqPrev_r;
    assign eligible_s     = mask_s[7] ? (pending_r & mask_s[6:0]) : 7'd0;
    assign dispIdx_s      = lowestSet(eligible_s);
    assign w1c_s          = (busWrite_s && (dir == BASE)) ? din[6:0] : 7'd0;
    assign dispatchClr_s  = dispatch_s ? (7'd1 << dispIdx_s) : 7'd0;
    assign unusedDinMsb_s = din[7];

`ifdef INTC_MASK_REG_EN
    logic [7:0] mask_r;

    // Mask register, written from the bus; decisions this cycle still see the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= 8'hFF;
        end else if (busWrite_s && (dir == (BASE + 16'd1))) begin
            mask_r <= din;
        end else begin
            mask_r <= mask_r;
        end
    end

    assign mask_s = mask_r;
`else
    assign mask_s = 8'hFF;
`endif

    // Next-state logic: dispatch only from IDLE, no nesting until iret.
    always_comb begin
        nextState_s = state_r;
        dispatch_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (eligible_s != 7'd0) begin
                    nextState_s = DISPATCH;
                    dispatch_s  = 1'b1;
                end else begin
                    nextState_s = IDLE;
                end
            end
            DISPATCH: nextState_s = SERVICE;
            SERVICE: begin
                if (iret) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = SERVICE;
                end
            end
            default: nextState_s = IDLE;
        endcase
    end

    // State, edge-detect history, pending bits and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            irqPrev_r      <= 7'd0;
            pending_r      <= 7'd0;
            interrupciones <= 3'd0;
            in_service     <= 1'b0;
        end else begin
            state_r        <= nextState_s;
            irqPrev_r      <= irq;
            // A fresh edge wins over both clear sources.
            pending_r      <= (pending_r & ~(w1c_s | dispatchClr_s)) | rise_s;
            interrupciones <= dispatch_s ? (dispIdx_s + 3'd1) : 3'd0;
            in_service     <= (nextState_s != IDLE);
        end
    end

    // Side-effect-free combinational read port.
    always_comb begin
        dout = 8'h00;
        if (busRead_s && (dir == BASE)) begin
            dout = {1'b0, pending_r};
        end else if (busRead_s && (dir == (BASE + 16'd1))) begin
            dout = mask_s;
        end else begin
            dout = 8'h00;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized self-checking bench for interrupt_controller against a behavioural model.
// Honours INTC_MASK_REG_EN the same way the design does.
module tb_interrupt_controller;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  irq;
    logic        iret;
    logic        enable_wishbone;
    logic        wr;
    logic [15:0] dir;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [2:0]  interrupciones;
    logic        in_service;

    int errCount   = 0;
    int checkCount = 0;

    // Behavioural model state
    logic [6:0] mPend;
    logic [6:0] mPrev;
    logic [7:0] mMask;
    int         mCode;
    bit         mBusy;

    interrupt_controller #(.BASE(BASE)) dut (
        .clk(clk), .reset(reset), .irq(irq), .iret(iret),
        .enable_wishbone(enable_wishbone), .wr(wr), .dir(dir), .din(din),
        .dout(dout), .interrupciones(interrupciones), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expDout();
        if (enable_wishbone && !wr && dir == BASE) return {1'b0, mPend};
        if (enable_wishbone && !wr && dir == BASE + 16'd1) return mMask;
        return 8'h00;
    endfunction

    task automatic modelReset();
        mPend = 7'd0; mPrev = 7'd0; mMask = 8'hFF; mCode = 0; mBusy = 1'b0;
    endtask

    // One rising edge of the reference: dispatch lowest eligible, hold one cycle, wait for iret.
    task automatic modelEdge();
        logic [6:0] clr;
        logic [6:0] rise;
        int newCode;
        rise = irq & ~mPrev;
        clr = (enable_wishbone && wr && dir == BASE) ? din[6:0] : 7'd0;
        newCode = 0;
        if (!mBusy) begin
            for (int i = 0; i < 7; i++) begin
                if (newCode == 0 && mPend[i] && mMask[i] && mMask[7]) begin
                    newCode = i + 1;
                    clr[i] = 1'b1;
                end
            end
            if (newCode != 0) mBusy = 1'b1;
        end else if (mCode == 0 && iret) begin
            mBusy = 1'b0;
        end
`ifdef INTC_MASK_REG_EN
        if (enable_wishbone && wr && dir == BASE + 16'd1) mMask = din;
`endif
        mPend = (mPend & ~clr) | rise;
        mPrev = irq;
        mCode = newCode;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkVal({tag, "_code"}, 32'(interrupciones), 32'(mCode));
        checkVal({tag, "_insvc"}, 32'(in_service), 32'(mBusy));
        checkVal({tag, "_dout"}, 32'(dout), 32'(expDout()));
    endtask

    task automatic drive(input string tag, input logic [6:0] irqV, input logic iretV,
                         input logic enV, input logic wrV, input logic [15:0] dirV,
                         input logic [7:0] dinV);
        irq = irqV; iret = iretV; enable_wishbone = enV; wr = wrV; dir = dirV; din = dinV;
        cycle(tag);
    endtask

    task automatic idle(input string tag);
        drive(tag, 7'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    // Pulse iret once the model reaches SERVICE; bounded so a stuck DUT cannot hang the run.
    task automatic finishService(input string tag);
        for (int k = 0; k < 8 && mBusy; k++) begin
            drive(tag, 7'd0, (mCode == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        end
        checkVal({tag, "_drained"}, 32'(in_service), 32'd0);
    endtask

    initial begin
        reset = 1'b1; irq = 7'd0; iret = 1'b0; enable_wishbone = 1'b0;
        wr = 1'b0; dir = 16'h0000; din = 8'h00;
        modelReset();
        #2;
        checkVal("rst_code", 32'(interrupciones), 32'd0);
        checkVal("rst_insvc", 32'(in_service), 32'd0);
        enable_wishbone = 1'b1; dir = BASE; #1;
        checkVal("rst_pend", 32'(dout), 32'h00);
        dir = BASE + 16'd1; #1;
        checkVal("rst_mask", 32'(dout), 32'hFF);
        enable_wishbone = 1'b0;
        @(negedge clk); reset = 1'b0;

        // Single pulse on source 3
        drive("p3", 7'h08, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        idle("p3a");
        checkVal("p3_code4", 32'(interrupciones), 32'd4);
        idle("p3b");
        checkVal("p3_code0", 32'(interrupciones), 32'd0);
        checkVal("p3_svc", 32'(in_service), 32'd1);
        drive("p3i", 7'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        checkVal("p3_iret", 32'(in_service), 32'd0);

        // Sources 5 and 1 together
        drive("p51", 7'h22, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        idle("p51a");
        checkVal("p51_code2", 32'(interrupciones), 32'd2);
        drive("p51r", 7'd0, 1'b0, 1'b1, 1'b0, BASE, 8'h00);
        checkVal("p51_pend20", 32'(dout), 32'h20);
        drive("p51i", 7'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
        idle("p51b");
        checkVal("p51_code6", 32'(interrupciones), 32'd6);
        finishService("p51f");

        // Masked source 0
        drive("mw", 7'd0, 1'b0, 1'b1, 1'b1, BASE + 16'd1, 8'hFE);
        drive("m0", 7'h01, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        idle("m0a");
        idle("m0b");
`ifdef INTC_MASK_REG_EN
        checkVal("m0_nodisp", 32'(in_service), 32'd0);
        drive("m0r", 7'd0, 1'b0, 1'b1, 1'b0, BASE, 8'h00);
        checkVal("m0_pend01", 32'(dout), 32'h01);
        drive("mwff", 7'd0, 1'b0, 1'b1, 1'b1, BASE + 16'd1, 8'hFF);
        idle("m0c");
        checkVal("m0_code1", 32'(interrupciones), 32'd1);
`else
        drive("m0r", 7'd0, 1'b0, 1'b1, 1'b0, BASE + 16'd1, 8'h00);
        checkVal("m0_maskfixed", 32'(dout), 32'hFF);
`endif
        finishService("m0f");

        // Edge beats W1C during SERVICE
        drive("w4", 7'h10, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        idle("w4a");
        idle("w4b");
        drive("w4c", 7'h04, 1'b0, 1'b1, 1'b1, BASE, 8'h04);
        drive("w4r", 7'd0, 1'b0, 1'b1, 1'b0, BASE, 8'h00);
        checkVal("w4_pend04", 32'(dout), 32'h04);
        drive("w4clr", 7'd0, 1'b0, 1'b1, 1'b1, BASE, 8'h04);
        drive("w4r2", 7'd0, 1'b0, 1'b1, 1'b0, BASE, 8'h00);
        checkVal("w4_pend00", 32'(dout), 32'h00);
        finishService("w4f");

        // Reset in the middle of DISPATCH
        drive("rd", 7'h40, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        idle("rda");
        checkVal("rd_code7", 32'(interrupciones), 32'd7);
        #2 reset = 1'b1;
        #1;
        checkVal("rd_code0", 32'(interrupciones), 32'd0);
        checkVal("rd_insvc0", 32'(in_service), 32'd0);
        modelReset();
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 4; k++) idle("rdq");
        checkVal("rd_nodisp", 32'(in_service), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            logic [6:0]  irqV;
            logic        enV;
            logic        wrV;
            logic [15:0] dirV;
            logic [7:0]  dinV;
            int          sel;
            irqV = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            sel  = $urandom_range(0, 9);
            dinV = 8'($urandom);
            enV = 1'b1; wrV = 1'b0; dirV = 16'h1234;
            case (sel)
                0: begin wrV = 1'b1; dirV = BASE + 16'd1;
                         if ($urandom_range(0, 3) != 0) dinV[7] = 1'b1; end
                1: begin wrV = 1'b1; dirV = BASE; end
                2: dirV = BASE;
                3: dirV = BASE + 16'd1;
                4: dirV = 16'($urandom);
                default: enV = 1'b0;
            endcase
            drive("rnd", irqV, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, enV, wrV, dirV, dinV);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
